shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, the successor to the fixed 5-bit left-shift chain. It adds configurable width, a programmable reset pattern, and six operating modes: shift either direction, rotate either direction, parallel load, and zero. A burst engine runs N back-to-back operations from a single start pulse, with a busy/done handshake. It sits between serial/parallel converters and the datapath in the guide exercises.

## Interface
- WIDTH, 5, register width in bits (≥2)
- RESET_VAL, {WIDTH{1'b1}}, value q takes while clear is asserted
- CNT_W, 4, width of burst count input
- clk  input  1  clock, all state on rising edge
- clear  input  1  asynchronous, active-low reset
- en  input  1  single-step enable (ignored while busy)
- mode  input  3  operation select (encoding below)
- sin_l  input  1  serial in at MSB end (used by shift right)
- sin_r  input  1  serial in at LSB end (used by shift left)
- load_data  input  WIDTH  parallel load value
- start  input  1  begin burst of count operations of mode
- count  input  CNT_W  burst length
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational
- sout_r  output  1  q[0], combinational
- busy  output  1  burst in progress
- done  output  1  one-cycle burst-complete pulse

## Operation
- Reset: clk and clear are the only clock and reset. clear is asynchronous and active-low. While clear=0: q=RESET_VAL, busy=0, done=0, internal counter=0, latched mode=000. Reset mid-burst aborts the burst with no done pulse.
- Mode encoding, applied to q at an operation edge:
  - 000 hold
  - 001 shift left: q <= {q[W-2:0], sin_r}
  - 010 shift right: q <= {sin_l, q[W-1:1]}
  - 011 rotate left: q <= {q[W-2:0], q[W-1]}
  - 100 rotate right: q <= {q[0], q[W-1:1]}
  - 101 parallel load: q <= load_data
  - 110 zero: q <= 0
  - 111 hold (reserved)
- Idle (busy=0):
  - start=1 has priority over en. It latches mode and count, and q is not modified on that edge.
  - Otherwise, en=1 performs one operation of the live mode.
  - en=0 holds.
- Burst (busy=1):
  - One operation of the latched mode per edge, count times.
  - en, mode, start and count are ignored.
  - sin_l, sin_r and load_data are sampled live at each edge.
- count=0: busy is high for one cycle, no operation is performed, then done pulses.
- A done pulse coincides with busy falling. A new start may be presented in the same cycle done is high; it is accepted, because busy is already 0.
- Counter wraps nothing: the maximum burst is 2^CNT_W−1 operations.

## Timing
- Single-step: an operation at edge T is visible on q after T, so latency is 1 cycle.
- Burst accepted at edge T with count=n≥1:
  - busy=1 after T.
  - Operations occur at edges T+1 … T+n.
  - At edge T+n, busy goes to 0 and done goes to 1.
  - done returns to 0 at edge T+n+1.
- Burst with count=0: busy=1 after T, busy=0 and done=1 after T+1.
- sout_l and sout_r follow q combinationally, with no extra delay.
- Output values during reset: q=RESET_VAL, busy=0, done=0, sout_l=RESET_VAL[W-1], sout_r=RESET_VAL[0].

## Test plan
- Reset: clear=0 asynchronously, mid-cycle, with WIDTH=5 → q=11111 immediately, busy=0, done=0. Release clear, hold en=0 for 3 edges → q stays 11111.
- Shift left with serial feed:
  - From q=11111, en=1, mode=001, sin_r sequence 0,1,0,0,0 over 5 edges → q after each edge = 11110, 11101, 11010, 10100, 01000.
  - sout_l matches q[4] at each step.
- Load then rotate:
  - mode=101, load_data=10011, en=1 → q=10011.
  - mode=100 for one edge → q=11001.
  - mode=011 for two edges → q=00111.
- Burst:
  - q=00001, start=1, mode=001, count=3, sin_r=0 → busy rises after edge T.
  - q after T+1, T+2, T+3 = 00010, 00100, 01000.
  - done=1 for exactly the cycle after T+3.
  - Toggling mode and en during the burst has no effect.
- Edge cases:
  - count=0 burst → busy high for 1 cycle, q unchanged, done pulses.
  - start and en both high while idle → start wins and q is unchanged on that edge.
  - A start in the cycle done=1 → accepted, with a second busy period.
- Abort: clear=0 at edge T+2 of a count=5 burst → q=11111, busy=0, no done pulse. After release, en=1 with mode=010 and sin_l=0 → q=01111.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate either way, parallel load, zero, with a
// counted burst engine (start latches mode+count, busy for the run, done pulse at end).
module shift_reg_univ #(
  parameter int                 WIDTH     = 5,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}},
  parameter int                 CNT_W     = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  input  logic [CNT_W-1:0]   count,
  output logic [WIDTH-1:0]   q,
  output logic               sout_l,
  output logic               sout_r,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ZERO = 3'b110;

  logic [2:0]       mode_lat;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_q;

  // During a burst the latched mode drives the datapath; serial/load inputs stay live.
  assign op_mode = busy ? mode_lat : mode;

  always_comb begin
    op_q = q;
    case (op_mode)
      M_SHL:   op_q = {q[WIDTH-2:0], sin_r};
      M_SHR:   op_q = {sin_l, q[WIDTH-1:1]};
      M_ROL:   op_q = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   op_q = {q[0], q[WIDTH-1:1]};
      M_LOAD:  op_q = load_data;
      M_ZERO:  op_q = '0;
      default: op_q = q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q        <= RESET_VAL;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      mode_lat <= M_HOLD;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          q   <= op_q;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end else if (start) begin
        mode_lat <= mode;
        cnt      <= count;
        busy     <= 1'b1;
      end else if (en) begin
        q <= op_q;
      end
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed table-driven bench for shift_reg_univ at default parameters (WIDTH=5, CNT_W=4).
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [2:0] mode;
  logic       sin_l, sin_r;
  logic [4:0] load_data;
  logic       start;
  logic [3:0] count;
  logic [4:0] q;
  logic       sout_l, sout_r, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  shift_reg_univ dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .load_data(load_data), .start(start), .count(count), .q(q),
    .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [4:0] ld;
    logic       start;
    logic [3:0] cnt;
    logic [4:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic e, input logic [2:0] m, input logic sl,
                     input logic sr, input logic [4:0] ld, input logic st, input logic [3:0] c,
                     input logic [4:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.name = nm; v.en = e; v.mode = m; v.sin_l = sl; v.sin_r = sr; v.ld = ld;
    v.start = st; v.cnt = c; v.eq = eq; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] eq, input logic eb, input logic ed);
    chk({nm, ".q"},      32'(q),      32'(eq));
    chk({nm, ".busy"},   32'(busy),   32'(eb));
    chk({nm, ".done"},   32'(done),   32'(ed));
    chk({nm, ".sout_l"}, 32'(sout_l), 32'(eq[4]));
    chk({nm, ".sout_r"}, 32'(sout_r), 32'(eq[0]));
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic sl, input logic sr,
                       input logic [4:0] ld, input logic st, input logic [3:0] c);
    en = e; mode = m; sin_l = sl; sin_r = sr; load_data = ld; start = st; count = c;
  endtask

  initial begin
    //   name        en mode  sl sr ld       st cnt   exp_q    busy done
    add("hold0",     0, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b11111, 0, 0);
    add("hold1",     0, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b11111, 0, 0);
    add("hold2",     0, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b11111, 0, 0);
    add("shl0",      1, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b11110, 0, 0);
    add("shl1",      1, 3'd1, 0, 1, 5'h00,   0, 4'd0, 5'b11101, 0, 0);
    add("shl2",      1, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b11010, 0, 0);
    add("shl3",      1, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b10100, 0, 0);
    add("shl4",      1, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b01000, 0, 0);
    add("load",      1, 3'd5, 0, 0, 5'b10011,0, 4'd0, 5'b10011, 0, 0);
    add("ror",       1, 3'd4, 0, 0, 5'h00,   0, 4'd0, 5'b11001, 0, 0);
    add("rol0",      1, 3'd3, 0, 0, 5'h00,   0, 4'd0, 5'b10011, 0, 0);
    add("rol1",      1, 3'd3, 0, 0, 5'h00,   0, 4'd0, 5'b00111, 0, 0);
    add("load1",     1, 3'd5, 0, 0, 5'b00001,0, 4'd0, 5'b00001, 0, 0);
    // burst of 3 shift-lefts; mode/en/load_data toggled during it must not matter
    add("b3_start",  0, 3'd1, 0, 0, 5'h00,   1, 4'd3, 5'b00001, 1, 0);
    add("b3_op1",    1, 3'd6, 0, 0, 5'h00,   0, 4'd0, 5'b00010, 1, 0);
    add("b3_op2",    1, 3'd5, 0, 0, 5'h1F,   1, 4'd9, 5'b00100, 1, 0);
    add("b3_op3",    0, 3'd3, 0, 0, 5'h00,   0, 4'd0, 5'b01000, 0, 1);
    add("b3_after",  0, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b01000, 0, 0);
    add("b0_start",  0, 3'd1, 0, 1, 5'h00,   1, 4'd0, 5'b01000, 1, 0);
    add("b0_end",    0, 3'd1, 0, 1, 5'h00,   0, 4'd0, 5'b01000, 0, 1);
    add("b0_after",  0, 3'd1, 0, 1, 5'h00,   0, 4'd0, 5'b01000, 0, 0);
    add("st_en",     1, 3'd6, 0, 0, 5'h00,   1, 4'd1, 5'b01000, 1, 0);
    add("st_en_op",  0, 3'd1, 0, 0, 5'h00,   0, 4'd0, 5'b00000, 0, 1);
    add("bb_start",  0, 3'd5, 0, 0, 5'h00,   1, 4'd2, 5'b00000, 1, 0);
    add("bb_op1",    0, 3'd0, 0, 0, 5'b10101,0, 4'd0, 5'b10101, 1, 0);
    add("bb_op2",    0, 3'd0, 0, 0, 5'b01010,0, 4'd0, 5'b01010, 0, 1);
    add("bb_after",  0, 3'd0, 0, 0, 5'h00,   0, 4'd0, 5'b01010, 0, 0);
    add("rsvd111",   1, 3'd7, 1, 1, 5'h1F,   0, 4'd0, 5'b01010, 0, 0);
    add("hold000",   1, 3'd0, 1, 1, 5'h1F,   0, 4'd0, 5'b01010, 0, 0);
    add("shr",       1, 3'd2, 1, 0, 5'h00,   0, 4'd0, 5'b10101, 0, 0);

    clear = 1'b1;
    drive(0, 3'd0, 0, 0, 5'h00, 0, 4'd0);
    #3 clear = 1'b0;
    #1 chk_all("reset_async", 5'b11111, 0, 0);
    @(posedge clk); #1 chk_all("reset_held", 5'b11111, 0, 0);
    @(negedge clk) clear = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sin_l, vecs[i].sin_r, vecs[i].ld,
            vecs[i].start, vecs[i].cnt);
      @(posedge clk); #1;
      chk_all(vecs[i].name, vecs[i].eq, vecs[i].eb, vecs[i].ed);
      @(negedge clk);
    end

    // abort: count=5 burst, clear asserted just before edge T+2
    drive(0, 3'd1, 0, 0, 5'h00, 1, 4'd5);
    @(posedge clk); #1 chk_all("ab_start", 5'b10101, 1, 0);
    @(negedge clk) drive(0, 3'd0, 0, 0, 5'h00, 0, 4'd0);
    @(posedge clk); #1 chk_all("ab_op1", 5'b01010, 1, 0);
    @(negedge clk); #4 clear = 1'b0;
    #0.5 chk_all("ab_clear", 5'b11111, 0, 0);
    @(posedge clk); #1 chk_all("ab_held", 5'b11111, 0, 0);
    @(negedge clk) clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 chk_all("ab_nodone", 5'b11111, 0, 0);
    end
    @(negedge clk) drive(1, 3'd2, 0, 0, 5'h00, 0, 4'd0);
    @(posedge clk); #1 chk_all("ab_shr", 5'b01111, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
